// File: rtl/key_event_detect.sv
// Classifies a debounced active-low key into click, double-click, long-press
// and auto-repeat pulses; one shared interval counter times every state.
module key_event_detect #(
  parameter int unsigned          CNT_W       = 26,
  parameter logic [CNT_W-1:0]     LONG_TIME   = 26'd25_000_000,
  parameter logic [CNT_W-1:0]     DBL_GAP     = 26'd12_500_000,
  parameter logic [CNT_W-1:0]     REPEAT_TIME = 26'd5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_lvl,
  output logic click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic long_active,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_LAST = LONG_TIME - CNT_W'(1);
  localparam logic [CNT_W-1:0] DBL_LAST  = DBL_GAP - CNT_W'(1);
  localparam logic [CNT_W-1:0] REP_LAST  = REPEAT_TIME - CNT_W'(1);
  localparam logic             REP_EN    = (REPEAT_TIME != '0);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESS1    = 3'd1,
    S_WAIT2     = 3'd2,
    S_PRESS2    = 3'd3,
    S_LONG_HOLD = 3'd4
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             key_q;
  logic             press_c;

  // Falling edge of the key level starts a new sequence
  assign press_c = key_q & ~key_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      key_q        <= 1'b1;
      click        <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      long_active  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      key_q        <= key_lvl;
      click        <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      if (state_q != S_IDLE) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      // Release is always tested before the timeout of the same state
      case (state_q)
        S_IDLE: begin
          if (press_c) begin
            state_q <= S_PRESS1;
            cnt_q   <= '0;
            busy    <= 1'b1;
          end
        end
        S_PRESS1: begin
          if (key_lvl) begin
            state_q <= S_WAIT2;
            cnt_q   <= '0;
          end else if (cnt_q == LONG_LAST) begin
            state_q     <= S_LONG_HOLD;
            cnt_q       <= '0;
            long_press  <= 1'b1;
            long_active <= 1'b1;
          end
        end
        S_WAIT2: begin
          if (!key_lvl) begin
            state_q <= S_PRESS2;
            cnt_q   <= '0;
          end else if (cnt_q == DBL_LAST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            click   <= 1'b1;
            busy    <= 1'b0;
          end
        end
        S_PRESS2: begin
          if (key_lvl) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            double_click <= 1'b1;
            busy         <= 1'b0;
          end else if (cnt_q == LONG_LAST) begin
            // First press was a click; the second became a long hold
            state_q     <= S_LONG_HOLD;
            cnt_q       <= '0;
            click       <= 1'b1;
            long_press  <= 1'b1;
            long_active <= 1'b1;
          end
        end
        S_LONG_HOLD: begin
          if (key_lvl) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            long_active <= 1'b0;
            busy        <= 1'b0;
          end else if (REP_EN && (cnt_q == REP_LAST)) begin
            cnt_q        <= '0;
            repeat_pulse <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cnt_q       <= '0;
          long_active <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_detect.sv
// Directed bench for key_event_detect: per-edge expected output vectors
// {click, double_click, long_press, repeat_pulse, long_active, busy}.
module tb_key_event_detect;

  logic clk;
  logic rst_n;
  logic key_lvl;
  logic click, double_click, long_press, repeat_pulse, long_active, busy;

  int n_checks = 0;
  int n_fail   = 0;

  key_event_detect #(
    .CNT_W      (4),
    .LONG_TIME  (4'd8),
    .DBL_GAP    (4'd6),
    .REPEAT_TIME(4'd4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_lvl     (key_lvl),
    .click       (click),
    .double_click(double_click),
    .long_press  (long_press),
    .repeat_pulse(repeat_pulse),
    .long_active (long_active),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {click, double_click, long_press, repeat_pulse, long_active, busy};
  endfunction

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_rng(int e, int lo, int hi);
    return (e >= lo) && (e <= hi);
  endfunction

  // Key level driven during the cycle that follows edge e
  function automatic logic key_at(int sc, int e);
    case (sc)
      0: return !in_rng(e, 9, 11);
      1: return !(in_rng(e, 9, 11) || in_rng(e, 14, 15));
      2: return !in_rng(e, 9, 29);
      3: return !in_rng(e, 9, 16);
      default: return !(in_rng(e, 9, 11) || in_rng(e, 14, 30));
    endcase
  endfunction

  // Expected outputs sampled just after edge e
  function automatic logic [5:0] exp_at(int sc, int e);
    logic c, d, l, r, la, b;
    c = 0; d = 0; l = 0; r = 0; la = 0; b = 0;
    case (sc)
      0: begin b = in_rng(e, 10, 18); c = (e == 19); end
      1: begin b = in_rng(e, 10, 16); d = (e == 17); end
      2: begin
        b  = in_rng(e, 10, 30);
        l  = (e == 18);
        la = in_rng(e, 18, 30);
        r  = (e == 22) || (e == 26) || (e == 30);
      end
      3: begin b = in_rng(e, 10, 23); c = (e == 24); end
      default: begin
        b  = in_rng(e, 10, 31);
        c  = (e == 23);
        l  = (e == 23);
        la = in_rng(e, 23, 31);
        r  = (e == 27) || (e == 31);
      end
    endcase
    return {c, d, l, r, la, b};
  endfunction

  task automatic run_scn(input int sc, input string name, input int last);
    key_lvl = 1'b1;
    repeat (3) step();
    for (int e = 9; e < last; e++) begin
      key_lvl = key_at(sc, e);
      step();
      check($sformatf("%s e%0d", name, e + 1), outs(), exp_at(sc, e + 1));
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    key_lvl = 1'b1;
    #12;
    check("reset", outs(), 6'b000000);
    step();
    rst_n = 1'b1;
    repeat (2) step();
    check("idle_after_reset", outs(), 6'b000000);

    run_scn(0, "single", 26);
    run_scn(1, "double", 28);
    run_scn(2, "long_rep", 36);
    run_scn(3, "tie", 30);
    run_scn(4, "press2_hold", 38);

    // Reset while long-held: outputs drop immediately, nothing follows
    key_lvl = 1'b1;
    repeat (3) step();
    key_lvl = 1'b0;
    repeat (10) step();
    check("pre_reset_hold", outs(), 6'b000011);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset", outs(), 6'b000000);
    key_lvl = 1'b1;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("post_reset c%0d", i), outs(), 6'b000000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_event_detect.md
Name: key_event_detect

Overview:
Consumes the debounced, active-low key level from the key debounce stage and classifies key activity into single-cycle event pulses: single click, double click, long press and auto-repeat while held. It sits directly downstream of the debouncer and feeds the application control logic (mode selection, counters, LED and display control). All outputs are registered.

Parameters:
CNT_W, 26, width of the shared interval counter.
LONG_TIME, 26'd25_000_000, cycles a press must be held to count as a long press.
DBL_GAP, 26'd12_500_000, maximum cycles after a release in which a second press forms a double click.
REPEAT_TIME, 26'd5_000_000, repeat-pulse interval while long-held; 0 disables repeat.
Constraints: LONG_TIME, DBL_GAP >= 2; REPEAT_TIME = 0 or >= 2; all values < 2^CNT_W.

Ports:
clk  input  1  clock; all logic on posedge
rst_n  input  1  reset, asynchronous, active-low
key_lvl  input  1  debounced key level; 1 = released, 0 = pressed; already synchronous to clk
click  output  1  one-cycle pulse: single short press confirmed
double_click  output  1  one-cycle pulse: two short presses within DBL_GAP
long_press  output  1  one-cycle pulse: key held LONG_TIME cycles
repeat_pulse  output  1  one-cycle pulse every REPEAT_TIME cycles while long-held
long_active  output  1  level, high while in LONG_HOLD
busy  output  1  level, high whenever state != IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; cnt 0; key_d (registered key_lvl) 1.
- press = key_d & ~key_lvl (combinational). release = key_lvl.
- cnt clears to 0 on every state change and otherwise increments by 1 each cycle in a non-IDLE state. cnt is not free-running in IDLE.
- Pulse outputs default to 0 every cycle and are set for exactly one cycle by the transition that generates them.
- States and transitions, evaluated per cycle, first match wins:
  - IDLE:
    - press -> PRESS1.
  - PRESS1:
    - release -> WAIT2.
    - cnt == LONG_TIME-1 -> LONG_HOLD, long_press = 1.
  - WAIT2:
    - ~key_lvl -> PRESS2.
    - cnt == DBL_GAP-1 -> IDLE, click = 1.
  - PRESS2:
    - release -> IDLE, double_click = 1.
    - cnt == LONG_TIME-1 -> LONG_HOLD; click = 1 and long_press = 1 in the same cycle.
  - LONG_HOLD:
    - release -> IDLE, no pulse.
    - REPEAT_TIME != 0 and cnt == REPEAT_TIME-1 -> stay in LONG_HOLD, repeat_pulse = 1, cnt <= 0.
- Release has priority over a timeout in the same cycle. A release seen while cnt == LONG_TIME-1 is a short press, not a long press.
- A press has priority over the DBL_GAP timeout in WAIT2.
- Latency: if the state enters PRESS1 at edge E and the key stays low, long_press is high in the cycle following edge E+LONG_TIME.
- click is emitted DBL_GAP cycles after entry to WAIT2. A single click is inherently delayed by the double-click window.
- long_active = (state == LONG_HOLD); busy = (state != IDLE). Both are registered together with the state.
- At most one of click or double_click fires per key sequence. long_press fires at most once per hold.
- Reset mid-operation: immediate return to IDLE, all outputs 0, and no pulse for the interrupted sequence.
- key_d resets to 1, matching the upstream stage's released reset level.
- Illegal state encodings recover to IDLE on the next cycle with no pulses.

Test Plan:
All scenarios use CNT_W=4, LONG_TIME=8, DBL_GAP=6, REPEAT_TIME=4.
- Single click: PRESS1 entered at edge 10; key_lvl returns to 1 before edge 13 (WAIT2 at 13) -> click high exactly between edges 19 and 20; no other pulses; busy low after edge 19.
- Double click: as above, key_lvl goes to 0 before edge 15 (PRESS2 at 15), then to 1 before edge 17 -> double_click high between edges 17 and 18; click never asserts.
- Long press with repeat: PRESS1 at edge 10, key held -> long_press high between edges 18 and 19; long_active high from edge 18; repeat_pulse high after edges 22, 26 and 30; release before edge 31 -> IDLE at 31, no further pulses.
- Release/timeout tie: PRESS1 at edge 10; key_lvl goes to 1 in the cycle after edge 17 (cnt == 7) -> WAIT2 at 18, long_press never asserts; click follows at edge 24.
- Second press held: PRESS2 entered and held 8 cycles -> click and long_press both high in the same single cycle, then repeat pulses as in the long-press scenario.
- Reset mid-operation: assert rst_n=0 while in LONG_HOLD -> all outputs 0 immediately; release reset with key_lvl=1 -> stays IDLE, no pulses for 20 cycles.
